// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready handshakes on both sides.
// Single-cycle ops answer in one cycle; MULT/DIV iterate one bit per clock.

`ifndef ALU_MC_OPS
`define ALU_MC_OPS
`define ALUOP_L    5
`define ALU_PASS   5'd0
`define ALU_ADD    5'd1
`define ALU_ADDC   5'd2
`define ALU_SUB    5'd3
`define ALU_SUBB   5'd4
`define ALU_SUBU   5'd5
`define ALU_SLL    5'd6
`define ALU_SRL    5'd7
`define ALU_SRA    5'd8
`define ALU_SLR    5'd9
`define ALU_SRR    5'd10
`define ALU_SEQ    5'd11
`define ALU_SLT    5'd12
`define ALU_SLTU   5'd13
`define ALU_AND    5'd14
`define ALU_OR     5'd15
`define ALU_XOR    5'd16
`define ALU_NOR    5'd17
`define ALU_NOT    5'd18
`define ALU_MULT   5'd19
`define ALU_MULTU  5'd20
`define ALU_DIV    5'd21
`define ALU_DIVU   5'd22
`endif

module alu_mc #(
    parameter int OPR_L = 32,
    parameter int ST_L  = 5,
    parameter int SH_L  = $clog2(OPR_L)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPR_L-1:0]    A,
    input  logic [OPR_L-1:0]    B,
    input  logic                c,
    input  logic [`ALUOP_L-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPR_L-1:0]    Y,
    output logic [OPR_L-1:0]    Y_hi,
    output logic [ST_L-1:0]     st
);

    localparam int M  = OPR_L - 1;
    localparam int CW = $clog2(OPR_L + 1);
    localparam logic [SH_L:0] WIDTH_AMT = (SH_L + 1)'(OPR_L);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_r, state_n;

    logic              out_valid_r;
    logic [OPR_L-1:0]  y_r, y_hi_r;
    logic [ST_L-1:0]   st_r;

    logic [OPR_L-1:0]  hi_r, lo_r, den_r, a_r;
    logic              neg_q_r, neg_r_r, div0_r, ovf_r, is_div_r;
    logic [CW-1:0]     cnt_r;

    logic              accept_s, is_mul_s, is_div_s, is_signed_s, last_s;
    logic [OPR_L-1:0]  mag_a_s, mag_b_s;

    logic [OPR_L:0]    sum_s;
    logic [OPR_L-1:0]  y_s;
    logic              cy_s, ov_s, ex_s;
    logic [SH_L-1:0]   sh_s;
    logic [SH_L:0]     rsh_s;

    logic [OPR_L:0]    mul_sum_s, div_sh_s, div_diff_s;
    logic [2*OPR_L-1:0] prod_s, prod_fix_s;
    logic [OPR_L-1:0]  fix_y_s, fix_hi_s;
    logic [ST_L-1:0]   fix_st_s;

    function automatic logic [ST_L-1:0] pack_st(input logic [OPR_L-1:0] y,
                                                input logic cy, input logic ov,
                                                input logic ex);
        logic [ST_L-1:0] s;
        s    = '0;
        s[0] = (y == {OPR_L{1'b0}});
        s[1] = y[M];
        s[2] = cy;
        s[3] = ov;
        s[4] = ex;
        return s;
    endfunction

    assign in_ready  = (state_r == IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign Y         = y_r;
    assign Y_hi      = y_hi_r;
    assign st        = st_r;

    assign is_mul_s    = (op == `ALU_MULT) || (op == `ALU_MULTU);
    assign is_div_s    = (op == `ALU_DIV)  || (op == `ALU_DIVU);
    assign is_signed_s = (op == `ALU_MULT) || (op == `ALU_DIV);
    assign last_s      = (cnt_r == CW'(OPR_L - 1));

    // Operand magnitudes handed to the iterative unit
    always_comb begin
        mag_a_s = (is_signed_s && A[M]) ? -A : A;
        mag_b_s = (is_signed_s && B[M]) ? -B : B;
    end

    // Single-cycle result and flags
    always_comb begin
        sum_s = '0;
        y_s   = '0;
        cy_s  = 1'b0;
        ov_s  = 1'b0;
        ex_s  = 1'b0;
        sh_s  = B[SH_L-1:0];
        rsh_s = WIDTH_AMT - {1'b0, sh_s};
        case (op)
            `ALU_PASS: y_s = A;
            `ALU_ADD, `ALU_ADDC: begin
                sum_s = {1'b0, A} + {1'b0, B}
                      + {{OPR_L{1'b0}}, (op == `ALU_ADDC) ? c : 1'b0};
                y_s   = sum_s[M:0];
                cy_s  = sum_s[OPR_L];
                ov_s  = (A[M] == B[M]) && (sum_s[M] != A[M]);
            end
            `ALU_SUB, `ALU_SUBB, `ALU_SUBU: begin
                sum_s = {1'b0, A} - {1'b0, B}
                      - {{OPR_L{1'b0}}, (op == `ALU_SUBB) ? c : 1'b0};
                y_s   = sum_s[M:0];
                cy_s  = sum_s[OPR_L];
                ov_s  = (op != `ALU_SUBU) && (A[M] != B[M]) && (sum_s[M] != A[M]);
            end
            `ALU_SLL:  y_s = A << sh_s;
            `ALU_SRL:  y_s = A >> sh_s;
            `ALU_SRA:  y_s = $signed(A) >>> sh_s;
            // A shift by the full width yields zero, so amount 0 returns A
            `ALU_SLR:  y_s = (A << sh_s) | (A >> rsh_s);
            `ALU_SRR:  y_s = (A >> sh_s) | (A << rsh_s);
            `ALU_SEQ:  y_s = {{M{1'b0}}, (A == B) ^ c};
            `ALU_SLT:  y_s = {{M{1'b0}}, ($signed(A) < $signed(B)) ^ c};
            `ALU_SLTU: y_s = {{M{1'b0}}, (A < B) ^ c};
            `ALU_AND:  y_s = A & B;
            `ALU_OR:   y_s = A | B;
            `ALU_XOR:  y_s = A ^ B;
            `ALU_NOR:  y_s = ~(A | B);
            `ALU_NOT:  y_s = ~A;
            `ALU_MULT, `ALU_MULTU, `ALU_DIV, `ALU_DIVU: y_s = '0;
            default:   ex_s = 1'b1;
        endcase
    end

    // One shift-add or restoring-subtract step
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, den_r} : {(OPR_L+1){1'b0}});
        div_sh_s   = {hi_r, lo_r[M]};
        div_diff_s = div_sh_s - {1'b0, den_r};
    end

    // Sign fix-up and final status for MULT/DIV
    always_comb begin
        prod_s     = {hi_r, lo_r};
        prod_fix_s = '0;
        fix_y_s    = '0;
        fix_hi_s   = '0;
        fix_st_s   = '0;
        if (is_div_r) begin
            if (div0_r) begin
                fix_y_s  = {OPR_L{1'b1}};
                fix_hi_s = a_r;
                fix_st_s = pack_st({OPR_L{1'b1}}, 1'b0, 1'b0, 1'b1);
            end else begin
                fix_y_s  = neg_q_r ? -lo_r : lo_r;
                fix_hi_s = neg_r_r ? -hi_r : hi_r;
                fix_st_s = pack_st(fix_y_s, 1'b0, ovf_r, 1'b0);
            end
        end else begin
            prod_fix_s = neg_q_r ? -prod_s : prod_s;
            fix_y_s    = prod_fix_s[M:0];
            fix_hi_s   = prod_fix_s[2*OPR_L-1:OPR_L];
            fix_st_s   = pack_st(fix_y_s, 1'b0, 1'b0, 1'b0);
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_n = MUL;
                end else if (accept_s && is_div_s) begin
                    state_n = DIV;
                end else begin
                    state_n = IDLE;
                end
            end
            MUL: begin
                if (last_s) begin
                    state_n = FIX;
                end else begin
                    state_n = MUL;
                end
            end
            DIV: begin
                if (last_s) begin
                    state_n = FIX;
                end else begin
                    state_n = DIV;
                end
            end
            FIX: state_n = DONE;
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath, iteration registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= '0;
            y_hi_r      <= '0;
            st_r        <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            den_r       <= '0;
            a_r         <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            div0_r      <= 1'b0;
            ovf_r       <= 1'b0;
            is_div_r    <= 1'b0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (is_mul_s || is_div_s)) begin
                        out_valid_r <= 1'b0;
                        hi_r        <= '0;
                        lo_r        <= mag_a_s;
                        den_r       <= mag_b_s;
                        a_r         <= A;
                        neg_q_r     <= is_signed_s && (A[M] ^ B[M]);
                        neg_r_r     <= is_signed_s && A[M];
                        div0_r      <= (B == {OPR_L{1'b0}});
                        ovf_r       <= (op == `ALU_DIV) && (A == {1'b1, {M{1'b0}}})
                                       && (B == {OPR_L{1'b1}});
                        is_div_r    <= is_div_s;
                        cnt_r       <= '0;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        y_r         <= y_s;
                        y_hi_r      <= '0;
                        st_r        <= pack_st(y_s, cy_s, ov_s, ex_s);
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                MUL: begin
                    hi_r  <= mul_sum_s[OPR_L:1];
                    lo_r  <= {mul_sum_s[0], lo_r[M:1]};
                    cnt_r <= cnt_r + CW'(1);
                end
                DIV: begin
                    if (!div_diff_s[OPR_L]) begin
                        hi_r <= div_diff_s[M:0];
                        lo_r <= {lo_r[M-1:0], 1'b1};
                    end else begin
                        hi_r <= div_sh_s[M:0];
                        lo_r <= {lo_r[M-1:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    y_r         <= fix_y_s;
                    y_hi_r      <= fix_hi_s;
                    st_r        <= fix_st_s;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed and random ops against a
// wide-integer reference model, plus backpressure and reset scenarios.

module tb_alu_mc;

    localparam int W = 32;
    localparam logic [4:0] OP_PASS = 5'd0,  OP_ADD  = 5'd1,  OP_ADDC = 5'd2,
                           OP_SUB  = 5'd3,  OP_SUBB = 5'd4,  OP_SUBU = 5'd5,
                           OP_SLL  = 5'd6,  OP_SRL  = 5'd7,  OP_SRA  = 5'd8,
                           OP_SLR  = 5'd9,  OP_SRR  = 5'd10, OP_SEQ  = 5'd11,
                           OP_SLT  = 5'd12, OP_SLTU = 5'd13, OP_AND  = 5'd14,
                           OP_OR   = 5'd15, OP_XOR  = 5'd16, OP_NOR  = 5'd17,
                           OP_NOT  = 5'd18, OP_MULT = 5'd19, OP_MULTU = 5'd20,
                           OP_DIV  = 5'd21, OP_DIVU = 5'd22;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         c = 1'b0;
    logic [4:0]   op = 5'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Y, Y_hi;
    logic [4:0]   st;

    int total = 0;
    int bad   = 0;

    alu_mc #(.OPR_L(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .c(c), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .Y(Y), .Y_hi(Y_hi), .st(st)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit integer arithmetic.
    task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic cc, output logic [31:0] y, output logic [31:0] yh,
                         output logic [4:0] s, output int lat);
        longint sa, sb, ua, ub, u, r, q, rm, k;
        logic [63:0] p;
        logic cy, ov, ex;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sh = int'(b[4:0]);
        y = 32'h0; yh = 32'h0; cy = 1'b0; ov = 1'b0; ex = 1'b0; lat = 1;
        k = (o == OP_ADDC || o == OP_SUBB) ? longint'(cc) : 64'sd0;
        case (o)
            OP_PASS: y = a;
            OP_ADD, OP_ADDC: begin
                u = ua + ub + k; y = u[31:0]; cy = (u > 64'sd4294967295);
                r = sa + sb + k; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            OP_SUB, OP_SUBB, OP_SUBU: begin
                u = ua - ub - k; y = u[31:0]; cy = (ua < ub + k);
                r = sa - sb - k;
                ov = (o != OP_SUBU) && ((r > 64'sd2147483647) || (r < -64'sd2147483648));
            end
            OP_SLL: y = a << sh;
            OP_SRL: y = a >> sh;
            OP_SRA: begin r = sa >>> sh; y = r[31:0]; end
            OP_SLR: y = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
            OP_SRR: y = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            OP_SEQ:  y = {31'h0, (a == b) ^ cc};
            OP_SLT:  y = {31'h0, (sa < sb) ^ cc};
            OP_SLTU: y = {31'h0, (ua < ub) ^ cc};
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            OP_NOT: y = ~a;
            OP_MULT: begin r = sa * sb; y = r[31:0]; yh = r[63:32]; lat = W + 2; end
            OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; y = p[31:0]; yh = p[63:32]; lat = W + 2; end
            OP_DIV, OP_DIVU: begin
                lat = W + 2;
                if (b == 32'h0) begin
                    y = 32'hFFFF_FFFF; yh = a; ex = 1'b1;
                end else if (o == OP_DIV) begin
                    q = sa / sb; rm = sa % sb; y = q[31:0]; yh = rm[31:0];
                    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end else begin
                    y = a / b; yh = a % b;
                end
            end
            default: ex = 1'b1;
        endcase
        s = {ex, ov, cy, y[31], y == 32'h0};
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic cc);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL issue_wait in_ready=%b required 1", in_ready);
        end
        op = o; A = a; B = b; c = cc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; op = 5'($urandom); c = 1'($urandom);
    endtask

    task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic cc);
        logic [31:0] ey, eh; logic [4:0] es; int elat, lat;
        model(o, a, b, cc, ey, eh, es, elat);
        issue(o, a, b, cc);
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        total += 4;
        if (lat !== elat) begin bad++; $display("FAIL %s latency got %0d want %0d", nm, lat, elat); end
        if (Y !== ey) begin bad++; $display("FAIL %s Y got %h want %h", nm, Y, ey); end
        if (Y_hi !== eh) begin bad++; $display("FAIL %s Y_hi got %h want %h", nm, Y_hi, eh); end
        if (st !== es) begin bad++; $display("FAIL %s st got %b want %b", nm, st, es); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (Y !== 32'h0) begin bad++; $display("FAIL reset Y got %h want 0", Y); end
        if (Y_hi !== 32'h0) begin bad++; $display("FAIL reset Y_hi got %h want 0", Y_hi); end
        if (st !== 5'h0) begin bad++; $display("FAIL reset st got %b want 0", st); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h5, 1'b0);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'h7, 32'h0, 1'b0);
        run_op("div_zero", OP_DIV, 32'h8000_0005, 32'h0, 1'b0);
        run_op("div_minneg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("srr_zero", OP_SRR, 32'h8000_0001, 32'h0, 1'b0);
        run_op("srr_four", OP_SRR, 32'h8000_0001, 32'h4, 1'b0);
        run_op("slr_zero", OP_SLR, 32'h8000_0001, 32'h20, 1'b0);
        run_op("slt_inv", OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1);
        run_op("subb_borrow", OP_SUBB, 32'h5, 32'h5, 1'b1);
        run_op("addc_carry", OP_ADDC, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_op("unknown_op", 5'd27, 32'h1234, 32'h5678, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] o; logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 5'($urandom_range(0, 31));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            run_op("random", o, a, b, 1'($urandom));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ey, eh, hy; logic [4:0] es, hs; int elat;
        run_op("sub_pre", OP_ADD, 32'h1, 32'h1, 1'b0);
        model(OP_SUB, 32'h10, 32'h20, 1'b0, ey, eh, es, elat);
        issue(OP_SUB, 32'h10, 32'h20, 1'b0);
        hy = Y; hs = st;
        total += 2;
        if (hy !== ey) begin bad++; $display("FAIL bp_sub Y got %h want %h", hy, ey); end
        if (hs !== es) begin bad++; $display("FAIL bp_sub st got %b want %b", hs, es); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = OP_AND; A = $urandom; B = $urandom;
            #1;
            total += 3;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold in_ready got %b want 0", in_ready); end
            if (Y !== ey) begin bad++; $display("FAIL bp_hold Y got %h want %h", Y, ey); end
            if (st !== es || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold st/valid got %b/%b want %b/1", st, out_valid, es);
            end
            @(posedge clk); #1;
        end
        model(OP_XOR, 32'hF0F0_0000, 32'h0F0F_1234, 1'b0, ey, eh, es, elat);
        op = OP_XOR; A = 32'hF0F0_0000; B = 32'h0F0F_1234; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next out_valid got %b want 1", out_valid); end
        if (Y !== ey || st !== es) begin bad++; $display("FAIL bp_next Y/st got %h/%b want %h/%b", Y, st, ey, es); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] o; logic [31:0] a, b, ey, eh; logic [4:0] es; logic cc; int elat, r;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 27));
            o = (r >= 19) ? 5'(r + 4) : 5'(r);
            a = $urandom; b = $urandom; cc = 1'($urandom);
            model(o, a, b, cc, ey, eh, es, elat);
            op = o; A = a; B = b; c = cc; in_valid = 1'b1;
            @(posedge clk); #1;
            total += 2;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b out_valid got %b want 1", out_valid); end
            if (Y !== ey || Y_hi !== eh || st !== es) begin
                bad++; $display("FAIL b2b op=%0d Y/Y_hi/st got %h/%h/%b want %h/%h/%b", o, Y, Y_hi, st, ey, eh, es);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain out_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        run_op("pre_div", OP_OR, 32'h00FF_0000, 32'h1, 1'b0);
        issue(OP_DIV, 32'h1234_5678, 32'h0000_0013, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_div out_valid got %b want 0", out_valid); end
        if (Y !== 32'h0 || Y_hi !== 32'h0 || st !== 5'h0) begin
            bad++; $display("FAIL rst_div Y/Y_hi/st got %h/%h/%b want 0/0/0", Y, Y_hi, st);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_div in_ready got %b want 1", in_ready); end
        run_op("add_after_rst", OP_ADD, 32'h2, 32'h3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parameterised integer ALU for the MIPS64 execute stage. It replaces the `run`/`ack` ALU with a clocked valid/ready handshake on both input and output. It adds iterative multiply and divide (signed and unsigned) with a HI/LO result pair and per-result status flags. Single-cycle ops finish in 1 cycle; MULT/DIV take a fixed OPR_L+2 cycles.

## Interface
- OPR_L, 32: operand/result width; any even value ≥ 8 (64 for MIPS64 datapath).
- ST_L, 5: status width; fixed bit map below, must be ≥ 5.
- SH_L, $clog2(OPR_L): shift-amount width taken from B[SH_L-1:0].
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- A, B  in  OPR_L  operands.
- c  in  1  carry/borrow in (ADDC/SUBB) or invert select (SEQ/SLT/SLTU).
- op  in  `ALUOP_L`  opcode from the team opcode header (`ALU_PASS` … `ALU_NOT`, `ALU_MULT`, `ALU_MULTU`, `ALU_DIV`, `ALU_DIVU`).
- out_valid  out  1  result held valid until consumed.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- Y  out  OPR_L  result / LO (product low half, quotient).
- Y_hi  out  OPR_L  HI (product high half, remainder); 0 for single-cycle ops.
- st  out  ST_L  st[0] zero (Y==0), st[1] neg (Y[OPR_L-1]), st[2] carry/borrow-out, st[3] signed overflow, st[4] exception.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back issue is allowed in the same cycle a result drains.
- IDLE, single-cycle op accepted: Y/st computed and registered; out_valid=1 next edge; state stays IDLE.
- IDLE, MULT/MULTU accepted: latch operand magnitudes (MULT: absolute values, record result sign). Go to MUL, OPR_L iterations of shift-add, one per clock. Then FIX.
- IDLE, DIV/DIVU accepted: restoring division, OPR_L iterations in DIV, then FIX.
- FIX: apply signs and write Y/Y_hi/st. Go to DONE with out_valid=1. On out_ready return to IDLE; stay in DONE while out_ready=0.
- Arithmetic rules:
  - ADD/ADDC/SUB/SUBB/SUBU are mod 2^OPR_L. st[2] is the carry-out (add) or borrow (sub). st[3] is signed overflow for ADD/ADDC/SUB/SUBB, 0 otherwise.
  - Shifts use B[SH_L-1:0]. SLR/SRR with amount 0 return A unchanged.
  - SEQ/SLT/SLTU return a 1-bit result zero-extended, XOR c.
  - MULT/MULTU return the full 2·OPR_L product {Y_hi,Y}.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV with A = most-negative and B = -1: Y=A, Y_hi=0, st[3]=1.
- Divide by zero (B==0, DIV/DIVU): Y = all ones, Y_hi = A, st[4]=1. Still takes the full OPR_L+2 latency.
- Unknown op: Y=0, Y_hi=0, st[4]=1, single-cycle.
- st[0]/st[1] always reflect the final Y. st bits not defined for an op are 0.

## Timing
- Reset (async, any state, including mid-MUL/DIV): state=IDLE, in_ready=1 after release, out_valid=0, Y=0, Y_hi=0, st=0. Any partial result is discarded.
- Single-cycle latency: accept at edge N gives out_valid at edge N+1.
- MULT/DIV latency: accept at edge N gives out_valid at edge N+OPR_L+2. in_ready=0 from N+1 until the result drains.
- Outputs (Y, Y_hi, st) stay stable while out_valid && !out_ready.
- in_valid/A/B/op are sampled only at acceptance; changes afterwards have no effect.

## Test plan
- Reset then ADD with A=0x7FFFFFFF, B=1, c=0 -> next cycle Y=0x80000000, st[3]=1, st[1]=1, st[2]=0.
- MULT with A=-3, B=5 (OPR_L=32) -> after 34 cycles {Y_hi,Y}=0xFFFFFFFF_FFFFFFF1, st[1]=1. MULTU with A=B=0xFFFFFFFF -> Y_hi=0xFFFFFFFE, Y=0x00000001.
- DIV with A=-7, B=2 -> Y=-3, Y_hi=-1. DIVU with A=7, B=0 -> Y=0xFFFFFFFF, Y_hi=7, st[4]=1, still 34-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after a SUB result -> Y/st stable and in_ready=0. Assert out_ready with a new in_valid in the same cycle -> both transfers occur and the next result appears one cycle later.
- Assert rst at iteration 10 of a DIV -> out_valid=0, Y=0 immediately. After release an ADD of 2+3 returns 5 in 1 cycle.
- SRR with A=0x80000001, B=0 -> Y=0x80000001. SRR with B=4 -> Y=0x18000000. SLT with A=-1, B=1, c=1 -> Y=0.
